// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_accept;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic [ID_W-1:0]    grant_id;
    logic               lock_active;
    logic               timeout_err;
    logic [7:0]         err_cnt;

    // The arbiter is the slave: it consumes requester bytes and the uart_tx busy flag.
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_accept, tx_data, tx_start, grant_id, lock_active, timeout_err, err_cnt
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_accept, tx_data, tx_start, grant_id, lock_active, timeout_err, err_cnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter sharing one uart_tx among requesters
module uart_tx_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    uart_tx_arbiter_if.slave   bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOCK, S_GUARD} state_e;

    state_e            state_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic              lock_active_q;
    logic              timeout_err_q;
    logic [7:0]        err_cnt_q;
    logic [CNT_W-1:0]  to_cnt_q;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              sel_valid;
    logic              sel_last;
    logic              fire;

    // Descending search so the nearest requester after rr_ptr is the one left standing.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(idx);
            end
        end
    end

    assign sel_valid = bus.req_valid[grant_id_q];
    assign sel_last  = bus.req_last[grant_id_q];
    assign fire      = (state_q == S_LOCK) && sel_valid && !bus.tx_busy;

    assign bus.tx_start    = fire;
    assign bus.tx_data     = bus.req_data[int'(grant_id_q) * 8 +: 8];
    assign bus.req_accept  = fire ? (N_REQ'(1) << grant_id_q) : '0;
    assign bus.grant_id    = grant_id_q;
    assign bus.lock_active = lock_active_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.err_cnt     = err_cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            grant_id_q    <= '0;
            rr_ptr_q      <= ID_W'(N_REQ - 1);
            lock_active_q <= 1'b0;
            timeout_err_q <= 1'b0;
            err_cnt_q     <= 8'd0;
            to_cnt_q      <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id_q    <= pick_idx;
                        lock_active_q <= 1'b1;
                        to_cnt_q      <= '0;
                        state_q       <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (fire) begin
                        to_cnt_q <= '0;
                        if (sel_last) begin
                            rr_ptr_q      <= grant_id_q;
                            lock_active_q <= 1'b0;
                            state_q       <= S_IDLE;
                        end else begin
                            state_q <= S_GUARD;
                        end
                    end else if (!sel_valid) begin
                        // Only valid-low cycles age the lock; a busy uart_tx never times it out.
                        if (to_cnt_q == TO_MAX) begin
                            to_cnt_q      <= '0;
                            rr_ptr_q      <= grant_id_q;
                            lock_active_q <= 1'b0;
                            timeout_err_q <= 1'b1;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
                            state_q <= S_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + CNT_W'(1);
                        end
                    end
                end
                // Covers the cycle before uart_tx raises tx_busy after a start.
                S_GUARD: state_q <= S_LOCK;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a packet-level round-robin model
module tb_uart_tx_arbiter;
    localparam int N   = 3;
    localparam int TO  = 16;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .ID_W(2), .TIMEOUT_CYC(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [9:0] sb_q [$];
    logic [8:0] chq [N][$];
    int exp_ptr = N - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (bus.tx_busy && n < 50) begin tick(); n++; end
        chk("tx_idle_wait", 32'(bus.tx_busy), 32'd0);
    endtask

    task automatic wait_accept(input int ch, input string name);
        int n = 0;
        logic got = 1'b0;
        while (!got && n < 30) begin
            @(negedge sys_clk);
            got = bus.req_accept[ch];
            n++;
        end
        chk(name, 32'(got), 32'd1);
        tick();
    endtask

    task automatic wait_timeout(output int n);
        n = 0;
        while (!bus.timeout_err && n < 40) begin tick(); n++; end
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < len; i++)
            chq[ch].push_back({(i == len - 1), rnd ? 8'($urandom) : base + 8'(i)});
    endtask

    // Whole packets are served round-robin among requesters that still have packets queued.
    task automatic run_engine();
        int mi[N];
        int pos[N];
        int gap[N];
        int ptr;
        int cyc;
        bit done;
        logic [N-1:0] acc;
        logic [8:0] e;
        ptr = exp_ptr;
        for (int c = 0; c < N; c++) begin mi[c] = 0; pos[c] = 0; gap[c] = 0; end
        forever begin
            int sel;
            sel = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (ptr + k) % N;
                if (sel < 0 && mi[c] < chq[c].size()) sel = c;
            end
            if (sel < 0) break;
            do begin
                e = chq[sel][mi[sel]];
                sb_q.push_back({2'(sel), e[7:0]});
                mi[sel]++;
            end while (!e[8]);
            ptr = sel;
        end
        exp_ptr = ptr;
        cyc = 0;
        forever begin
            done = 1'b1;
            for (int c = 0; c < N; c++) begin
                if (pos[c] < chq[c].size()) done = 1'b0;
                if (pos[c] < chq[c].size() && gap[c] == 0) begin
                    bus.req_valid[c] = 1'b1;
                    bus.req_data[8*c +: 8] = chq[c][pos[c]][7:0];
                    bus.req_last[c] = chq[c][pos[c]][8];
                end else begin
                    bus.req_valid[c] = 1'b0;
                    bus.req_last[c] = 1'b0;
                end
            end
            if (done) break;
            if (cyc >= 4000) begin
                chk("engine_cycle_budget", 32'(cyc), 32'd0);
                break;
            end
            @(negedge sys_clk);
            acc = bus.req_accept;
            tick();
            cyc++;
            for (int c = 0; c < N; c++) begin
                if (gap[c] > 0) gap[c]--;
                if (acc[c]) begin
                    if (!chq[c][pos[c]][8]) gap[c] = $urandom_range(0, 3);
                    pos[c]++;
                end
            end
        end
        bus.req_valid = '0;
        for (int c = 0; c < N; c++) chq[c].delete();
        tick();
        wait_tx_idle();
    endtask

    // uart_tx stand-in: busy from the cycle after a start for a short random frame.
    initial begin
        int bcnt;
        logic st;
        bus.tx_busy = 1'b0;
        bcnt = 0;
        forever begin
            @(negedge sys_clk);
            st = bus.tx_start;
            @(posedge sys_clk);
            #1;
            if (st) begin
                bus.tx_busy = 1'b1;
                bcnt = $urandom_range(2, 6);
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && bus.tx_start) begin
                chk("start_while_busy", 32'(bus.tx_busy), 32'd0);
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("grant_id", 32'(bus.grant_id), 32'(e[9:8]));
                    chk("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
                    chk("req_accept", 32'(bus.req_accept), 32'(3'b001 << e[9:8]));
                end
            end else if (sys_rst_n) begin
                chk("accept_without_start", 32'(bus.req_accept), 32'd0);
            end
        end
    end

    initial begin
        int n;
        bus.req_valid = 3'b111;
        bus.req_data  = {8'hC2, 8'hB1, 8'hA0};
        bus.req_last  = 3'b111;
        repeat (3) tick();
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_lock", 32'(bus.lock_active), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_accept", 32'(bus.req_accept), 32'd0);

        sb_q.push_back({2'd0, 8'hA0});
        sys_rst_n = 1'b1;
        tick();
        chk("first_grant", 32'(bus.grant_id), 32'd0);
        chk("first_lock", 32'(bus.lock_active), 32'd1);
        chk("first_tx_start", 32'(bus.tx_start), 32'd1);
        tick();
        bus.req_valid = '0;
        exp_ptr = 0;
        tick();
        wait_tx_idle();

        for (int i = 0; i < 4; i++) begin add_pkt(1, 1, 8'h0, 1'b1); add_pkt(2, 1, 8'h0, 1'b1); end
        run_engine();

        add_pkt(0, 4, 8'h41, 1'b0);
        add_pkt(2, 1, 8'h77, 1'b0);
        run_engine();

        bus.req_valid = 3'b010;
        bus.req_data[15:8] = 8'h5A;
        bus.req_last = 3'b000;
        sb_q.push_back({2'd1, 8'h5A});
        tick();
        chk("to_grant", 32'(bus.grant_id), 32'd1);
        wait_accept(1, "to_fire_seen");
        bus.req_valid = 3'b001;
        bus.req_data[7:0] = 8'h33;
        bus.req_last = 3'b001;
        sb_q.push_back({2'd0, 8'h33});
        wait_timeout(n);
        chk("to_latency", 32'(n), 32'd17);
        chk("to_err_cnt", 32'(bus.err_cnt), 32'd1);
        chk("to_lock_dropped", 32'(bus.lock_active), 32'd0);
        tick();
        chk("to_pulse_single", 32'(bus.timeout_err), 32'd0);
        chk("to_next_grant", 32'(bus.grant_id), 32'd0);
        chk("to_next_lock", 32'(bus.lock_active), 32'd1);
        wait_accept(0, "to_ch0_fire_seen");
        bus.req_valid = '0;
        exp_ptr = 0;
        tick();
        wait_tx_idle();

        bus.req_last = '0;
        for (int i = 0; i < 260; i++) begin
            bus.req_valid = 3'b001;
            tick();
            bus.req_valid = '0;
            wait_timeout(n);
            chk("sat_timeout_seen", 32'(bus.timeout_err), 32'd1);
            chk("sat_err_cnt", 32'(bus.err_cnt), 32'((i + 2 > 255) ? 255 : i + 2));
            tick();
        end
        exp_ptr = 0;

        wait_tx_idle();
        bus.req_valid = 3'b010;
        bus.req_data[15:8] = 8'h61;
        bus.req_last = 3'b000;
        sb_q.push_back({2'd1, 8'h61});
        tick();
        wait_accept(1, "ar_fire_seen");
        chk("ar_guard_lock", 32'(bus.lock_active), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("ar_lock", 32'(bus.lock_active), 32'd0);
        chk("ar_grant", 32'(bus.grant_id), 32'd0);
        chk("ar_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("ar_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("ar_tx_start", 32'(bus.tx_start), 32'd0);
        chk("ar_accept", 32'(bus.req_accept), 32'd0);
        bus.req_valid = 3'b011;
        bus.req_data[7:0] = 8'h70;
        bus.req_data[15:8] = 8'h62;
        bus.req_last = 3'b011;
        sb_q.push_back({2'd0, 8'h70});
        tick();
        sys_rst_n = 1'b1;
        tick();
        chk("ar_restart_grant", 32'(bus.grant_id), 32'd0);
        chk("ar_restart_lock", 32'(bus.lock_active), 32'd1);
        wait_accept(0, "ar_ch0_fire_seen");
        bus.req_valid = '0;
        exp_ptr = 0;
        tick();
        wait_tx_idle();

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N; c++)
                for (int p = $urandom_range(0, 3); p > 0; p--)
                    add_pkt(c, $urandom_range(1, 4), 8'h0, 1'b1);
            run_engine();
        end

        repeat (3) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single 8N1 UART transmitter between N_REQ byte-stream requesters, such as the CPU UART MMIO FIFO, a telemetry/status reporter and a debug dumper. It grants one requester at a time using round-robin order. The grant is packet-locked, so one requester's multi-byte frame is never interleaved with another's. It sits between the requester queues and uart_tx, in place of the direct FIFO-to-uart_tx handshake. A stall timeout prevents a dead requester from holding the UART forever.

Parameters:
N_REQ, 3, number of requesters (2..4)
ID_W, 2, width of grant_id; must be at least clog2(N_REQ)
TIMEOUT_CYC, 50000, sys_clk cycles a locked requester may keep req_valid low before the lock is dropped (1 ms at 50 MHz)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  per-requester byte available
req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  N_REQ  byte currently presented is the final byte of its packet
req_accept  out  N_REQ  one-hot pulse; the byte is consumed this cycle
tx_data  out  8  byte to uart_tx; valid when tx_start is high
tx_start  out  1  single-cycle start pulse to uart_tx
tx_busy  in  1  uart_tx busy; rises the cycle after tx_start and stays high until the stop bit ends
grant_id  out  ID_W  index of the locked requester
lock_active  out  1  a packet lock is held
timeout_err  out  1  single-cycle pulse when a lock is dropped by timeout
err_cnt  out  8  timeout count, saturates at 255

Behaviour:
- Reset (async, active-low, any time including mid-byte or mid-packet):
  - state=IDLE; grant_id=0; lock_active=0; timeout_err=0; err_cnt=0.
  - rr_ptr=N_REQ-1, so requester 0 has top priority on the first arbitration.
  - tx_start=0 and req_accept=0.
  - The byte already on the line is uart_tx's concern; the arbiter does not resume the interrupted packet.
- States: IDLE, LOCK, GUARD.
- IDLE:
  - If any req_valid is high, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Register that index into grant_id, set lock_active=1 and go to LOCK next cycle.
  - Arbitration latency is 1 cycle. tx_start is never high in IDLE.
- LOCK:
  - tx_start = req_valid[grant_id] & ~tx_busy (combinational).
  - tx_data = req_data slice selected by grant_id (combinational).
  - req_accept[grant_id] = tx_start; all other accept bits are 0.
  - On a fire with req_last[grant_id]=0: go to GUARD.
  - On a fire with req_last[grant_id]=1: go to IDLE, set rr_ptr<=grant_id and lock_active<=0.
  - Requests from other channels are ignored while locked.
- GUARD:
  - Lasts exactly 1 cycle, then returns to LOCK.
  - tx_start=0 regardless of tx_busy. This covers the 1-cycle latency before tx_busy rises.
- Timeout counter:
  - Cleared on entering LOCK and on every fire.
  - Increments each LOCK cycle in which req_valid[grant_id]=0.
  - Holds while req_valid is high but tx_busy blocks the fire.
  - When it reaches TIMEOUT_CYC-1 with valid still low:
    - go to IDLE, set lock_active=0 and rr_ptr<=grant_id;
    - pulse timeout_err for 1 cycle;
    - err_cnt<=err_cnt+1, saturating at 255.
  - A fire and a timeout cannot occur in the same cycle, because the counter only advances while valid is low.
- Single-byte packet: req_last is high on the first byte. The sequence is LOCK, fire, IDLE, with no GUARD.
- A requester dropping req_valid mid-packet is legal; the lock is held until req_last or timeout.
- grant_id holds its last value in IDLE.
- Back-to-back packets from the same requester are allowed. After release, that requester has the lowest priority.
- Throughput is one byte per uart_tx frame; the arbiter adds no idle bit-time when tx_busy falls.

Test Plan:
- Reset with req_valid=3'b111:
  - cycle after deassert: grant_id=0, lock_active=1;
  - tx_start on that cycle with tx_data = requester 0 byte.
- Round-robin, ch1 and ch2 sending 1-byte packets continuously:
  - grants alternate 1,2,1,2;
  - exactly one req_accept bit per tx_start;
  - tx_start never high while tx_busy=1 or in GUARD.
- Packet lock, ch0 sends 4 bytes 0x41..0x44 (last on 0x44) while ch2 is valid throughout:
  - tx_data sequence is 41,42,43,44;
  - then grant_id=2 after a 1-cycle IDLE.
- Stall timeout, TIMEOUT_CYC=16, ch1 sends 1 byte with last=0 and then drops valid:
  - after 16 cycles in LOCK with valid low: timeout_err pulses once, err_cnt=1, lock_active=0;
  - ch0 is then granted.
- err_cnt saturation: force 260 timeouts -> err_cnt=255.
- Asynchronous reset asserted mid-packet while in GUARD:
  - all outputs return to reset values immediately;
  - after release, arbitration restarts from requester 0.
